// File: rtl/raccoon_round_ctrl.sv
// raccoon_round_ctrl
// Round sequencer for the raccoon crossing game. Owns the game state, lives,
// score and level, and times the hit / win / game-over pauses in video frames.
// Publishes the per-level car speed divider and gates paddle control.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_Game_Start   start request (level, sampled in IDLE only)
//   i_Collision    paddle/car overlap (level)
//   i_Reached_Top  paddle at row 0 (level)
//   o_Game_Active  cars move (RUNNING or HIT)
//   o_Freeze       paddle input ignored (HIT or WIN)
//   o_Respawn      one-cycle pulse: paddle returns to its start position
//   o_State        IDLE=0, RUNNING=1, HIT=2, WIN=3, OVER=4
//   o_Level        current level
//   o_Car_Speed    registered car speed divider (clocks per pixel)
//   o_Life         remaining lives
//   o_Score        completed crossings, saturating at 255
module raccoon_round_ctrl #(
    parameter int c_LIFE          = 4,
    parameter int c_FREEZE_FRAMES = 60,
    parameter int c_WIN_FRAMES    = 90,
    parameter int c_OVER_FRAMES   = 180,
    parameter int c_BASE_SPEED    = 100000,
    parameter int c_SPEED_STEP    = 10000,
    parameter int c_MIN_SPEED     = 30000,
    parameter int c_MAX_LEVEL     = 15
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Frame_Tick,
    input  logic        i_Game_Start,
    input  logic        i_Collision,
    input  logic        i_Reached_Top,
    output logic        o_Game_Active,
    output logic        o_Freeze,
    output logic        o_Respawn,
    output logic [2:0]  o_State,
    output logic [3:0]  o_Level,
    output logic [19:0] o_Car_Speed,
    output logic [3:0]  o_Life,
    output logic [7:0]  o_Score
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RUNNING = 3'd1;
    localparam logic [2:0] HIT     = 3'd2;
    localparam logic [2:0] WIN     = 3'd3;
    localparam logic [2:0] OVER    = 3'd4;

    // Last timer value of each pause; the pause ends on the tick seen there.
    localparam logic [15:0] c_FREEZE_LAST = 16'(c_FREEZE_FRAMES - 1);
    localparam logic [15:0] c_FREEZE_HELD = 16'(c_FREEZE_FRAMES);
    localparam logic [15:0] c_WIN_LAST    = 16'(c_WIN_FRAMES - 1);
    localparam logic [15:0] c_OVER_LAST   = 16'(c_OVER_FRAMES - 1);
    localparam logic [3:0]  c_LIFE_4      = 4'(c_LIFE);
    localparam logic [3:0]  c_MAX_LEVEL_4 = 4'(c_MAX_LEVEL);

    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic [3:0]  r_life;
    logic [7:0]  r_score;
    logic [3:0]  r_level;
    logic [19:0] r_speed;
    logic        r_respawn;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_timer_nxt;
    logic [3:0]  w_life_nxt;
    logic [7:0]  w_score_nxt;
    logic [3:0]  w_level_nxt;
    logic        w_respawn_req;
    logic [31:0] w_speed_dec;
    logic [19:0] w_speed_nxt;

    // Next-state, timer and game-counter logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_life_nxt    = r_life;
        w_score_nxt   = r_score;
        w_level_nxt   = r_level;
        w_respawn_req = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Game_Start) begin
                    w_state_nxt   = RUNNING;
                    w_timer_nxt   = 16'd0;
                    w_life_nxt    = c_LIFE_4;
                    w_score_nxt   = 8'd0;
                    w_level_nxt   = 4'd0;
                    w_respawn_req = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUNNING: begin
                if (i_Reached_Top) begin
                    w_state_nxt = WIN;
                    w_timer_nxt = 16'd0;
                    w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                end else if (i_Collision && (r_life == 4'd1)) begin
                    w_state_nxt = OVER;
                    w_timer_nxt = 16'd0;
                    w_life_nxt  = 4'd0;
                end else if (i_Collision) begin
                    w_state_nxt   = HIT;
                    w_timer_nxt   = 16'd0;
                    w_life_nxt    = r_life - 4'd1;
                    w_respawn_req = 1'b1;
                end else begin
                    w_state_nxt = RUNNING;
                end
            end
            HIT: begin
                // Timer parked one past the last value means the freeze has
                // expired but a car still overlaps the respawn point.
                if (r_timer == c_FREEZE_HELD) begin
                    if (!i_Collision) begin
                        w_state_nxt = RUNNING;
                        w_timer_nxt = 16'd0;
                    end else begin
                        w_state_nxt = HIT;
                    end
                end else if (i_Frame_Tick) begin
                    if (r_timer != c_FREEZE_LAST) begin
                        w_timer_nxt = r_timer + 16'd1;
                    end else if (i_Collision) begin
                        w_timer_nxt = c_FREEZE_HELD;
                    end else begin
                        w_state_nxt = RUNNING;
                        w_timer_nxt = 16'd0;
                    end
                end else begin
                    w_state_nxt = HIT;
                end
            end
            WIN: begin
                if (i_Frame_Tick && (r_timer == c_WIN_LAST)) begin
                    w_state_nxt   = RUNNING;
                    w_timer_nxt   = 16'd0;
                    w_level_nxt   = (r_level >= c_MAX_LEVEL_4) ? r_level : r_level + 4'd1;
                    w_respawn_req = 1'b1;
                end else if (i_Frame_Tick) begin
                    w_timer_nxt = r_timer + 16'd1;
                end else begin
                    w_state_nxt = WIN;
                end
            end
            OVER: begin
                if (i_Frame_Tick && (r_timer == c_OVER_LAST)) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = 16'd0;
                end else if (i_Frame_Tick) begin
                    w_timer_nxt = r_timer + 16'd1;
                end else begin
                    w_state_nxt = OVER;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = 16'd0;
            end
        endcase
    end

    // Speed divider for the current level; the floor test is done on the sum
    // so the subtraction below can never underflow.
    always_comb begin
        w_speed_dec = {28'd0, r_level} * 32'(c_SPEED_STEP);
        if ((w_speed_dec + 32'(c_MIN_SPEED)) < 32'(c_BASE_SPEED)) begin
            w_speed_nxt = 20'(32'(c_BASE_SPEED) - w_speed_dec);
        end else begin
            w_speed_nxt = 20'(c_MIN_SPEED);
        end
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state   <= IDLE;
            r_timer   <= 16'd0;
            r_life    <= c_LIFE_4;
            r_score   <= 8'd0;
            r_level   <= 4'd0;
            r_speed   <= 20'(c_BASE_SPEED);
            r_respawn <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_life    <= w_life_nxt;
            r_score   <= w_score_nxt;
            r_level   <= w_level_nxt;
            r_speed   <= w_speed_nxt;
            // A request right after a pulse is dropped: the paddle is
            // already back at its start position.
            r_respawn <= w_respawn_req & ~r_respawn;
        end
    end

    assign o_State       = r_state;
    assign o_Game_Active = (r_state == RUNNING) || (r_state == HIT);
    assign o_Freeze      = (r_state == HIT) || (r_state == WIN);
    assign o_Respawn     = r_respawn;
    assign o_Level       = r_level;
    assign o_Car_Speed   = r_speed;
    assign o_Life        = r_life;
    assign o_Score       = r_score;

endmodule

// File: tb/tb_raccoon_round_ctrl.sv
// Directed testbench for raccoon_round_ctrl. Two instances: u_dut (4 lives)
// for the main flow and u_dut1 (1 life) for the game-over path.
module tb_raccoon_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tick, start, coll, top;
    logic        act, frz, resp;
    logic [2:0]  st;
    logic [3:0]  lvl, life;
    logic [19:0] spd;
    logic [7:0]  score;

    logic        rst1_n, tick1, start1, coll1, top1;
    logic        act1, frz1, resp1;
    logic [2:0]  st1;
    logic [3:0]  lvl1, life1;
    logic [19:0] spd1;
    logic [7:0]  score1;

    int n_checks = 0;
    int n_fail   = 0;

    raccoon_round_ctrl #(.c_LIFE(4), .c_FREEZE_FRAMES(3), .c_WIN_FRAMES(2), .c_OVER_FRAMES(3)) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Game_Start(start),
        .i_Collision(coll), .i_Reached_Top(top), .o_Game_Active(act), .o_Freeze(frz),
        .o_Respawn(resp), .o_State(st), .o_Level(lvl), .o_Car_Speed(spd),
        .o_Life(life), .o_Score(score));

    raccoon_round_ctrl #(.c_LIFE(1), .c_FREEZE_FRAMES(3), .c_WIN_FRAMES(2), .c_OVER_FRAMES(3)) u_dut1 (
        .i_Clk(clk), .i_Rst_L(rst1_n), .i_Frame_Tick(tick1), .i_Game_Start(start1),
        .i_Collision(coll1), .i_Reached_Top(top1), .o_Game_Active(act1), .o_Freeze(frz1),
        .o_Respawn(resp1), .o_State(st1), .o_Level(lvl1), .o_Car_Speed(spd1),
        .o_Life(life1), .o_Score(score1));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst1_n = 1'b0;
        tick = 1'b0; start = 1'b0; coll = 1'b0; top = 1'b0;
        tick1 = 1'b0; start1 = 1'b0; coll1 = 1'b0; top1 = 1'b0;
        step(2);
        n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", st); end
        n_checks++; if (life !== 4'd4) begin n_fail++; $display("FAIL reset_life got %0d exp 4", life); end
        n_checks++; if (score !== 8'd0 || lvl !== 4'd0) begin n_fail++; $display("FAIL reset_score_level got %0d/%0d exp 0/0", score, lvl); end
        n_checks++; if (spd !== 20'd100000) begin n_fail++; $display("FAIL reset_speed got %0d exp 100000", spd); end
        n_checks++; if ({act, frz, resp} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {act, frz, resp}); end
        rst_n = 1'b1; rst1_n = 1'b1;
        step(1);
    endtask

    task automatic test_start;
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (st !== 3'd1 || act !== 1'b1) begin n_fail++; $display("FAIL start_state got %0d act %b exp 1 act 1", st, act); end
        n_checks++; if (life !== 4'd4 || score !== 8'd0 || lvl !== 4'd0) begin n_fail++; $display("FAIL start_counters got %0d/%0d/%0d exp 4/0/0", life, score, lvl); end
        n_checks++; if (resp !== 1'b1) begin n_fail++; $display("FAIL start_respawn got %b exp 1", resp); end
        step(1);
        n_checks++; if (resp !== 1'b0) begin n_fail++; $display("FAIL start_respawn_width got %b exp 0", resp); end
        n_checks++; if (spd !== 20'd100000) begin n_fail++; $display("FAIL start_speed got %0d exp 100000", spd); end
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (st !== 3'd1 || life !== 4'd4) begin n_fail++; $display("FAIL start_ignored got %0d/%0d exp 1/4", st, life); end
    endtask

    task automatic test_hit;
        coll = 1'b1; step(1); coll = 1'b0;
        n_checks++; if (st !== 3'd2 || life !== 4'd3) begin n_fail++; $display("FAIL hit_entry got %0d/%0d exp 2/3", st, life); end
        n_checks++; if ({act, frz, resp} !== 3'b111) begin n_fail++; $display("FAIL hit_flags got %b exp 111", {act, frz, resp}); end
        coll = 1'b1; step(1); coll = 1'b0;
        n_checks++; if (st !== 3'd2 || life !== 4'd3 || resp !== 1'b0) begin n_fail++; $display("FAIL hit_second_coll got %0d/%0d/%b exp 2/3/0", st, life, resp); end
        tick = 1'b1; step(2);
        n_checks++; if (st !== 3'd2) begin n_fail++; $display("FAIL hit_two_ticks got %0d exp 2", st); end
        step(1); tick = 1'b0;
        n_checks++; if (st !== 3'd1 || life !== 4'd3) begin n_fail++; $display("FAIL hit_exit got %0d/%0d exp 1/3", st, life); end
    endtask

    task automatic test_hit_hold;
        coll = 1'b1; step(1);
        n_checks++; if (st !== 3'd2 || life !== 4'd2) begin n_fail++; $display("FAIL hold_entry got %0d/%0d exp 2/2", st, life); end
        tick = 1'b1; step(3); tick = 1'b0; step(2);
        n_checks++; if (st !== 3'd2 || life !== 4'd2) begin n_fail++; $display("FAIL hold_held got %0d/%0d exp 2/2", st, life); end
        coll = 1'b0; step(1);
        n_checks++; if (st !== 3'd1 || life !== 4'd2 || resp !== 1'b0) begin n_fail++; $display("FAIL hold_exit got %0d/%0d/%b exp 1/2/0", st, life, resp); end
    endtask

    task automatic test_win;
        top = 1'b1; coll = 1'b1; step(1); top = 1'b0; coll = 1'b0;
        n_checks++; if (st !== 3'd3 || score !== 8'd1 || life !== 4'd2) begin n_fail++; $display("FAIL win_entry got %0d/%0d/%0d exp 3/1/2", st, score, life); end
        n_checks++; if ({act, frz} !== 2'b01) begin n_fail++; $display("FAIL win_flags got %b exp 01", {act, frz}); end
        tick = 1'b1; step(1);
        n_checks++; if (st !== 3'd3 || lvl !== 4'd0) begin n_fail++; $display("FAIL win_one_tick got %0d/%0d exp 3/0", st, lvl); end
        step(1); tick = 1'b0;
        n_checks++; if (st !== 3'd1 || lvl !== 4'd1 || resp !== 1'b1) begin n_fail++; $display("FAIL win_exit got %0d/%0d/%b exp 1/1/1", st, lvl, resp); end
        n_checks++; if (spd !== 20'd100000) begin n_fail++; $display("FAIL win_speed_lag got %0d exp 100000", spd); end
        step(1);
        n_checks++; if (spd !== 20'd90000 || resp !== 1'b0) begin n_fail++; $display("FAIL win_speed got %0d/%b exp 90000/0", spd, resp); end
    endtask

    task automatic do_win;
        top = 1'b1; step(1); top = 1'b0;
        tick = 1'b1; step(2); tick = 1'b0; step(1);
    endtask

    task automatic test_levels;
        for (int i = 0; i < 7; i++) do_win();
        n_checks++; if (lvl !== 4'd8 || score !== 8'd8) begin n_fail++; $display("FAIL level8 got %0d/%0d exp 8/8", lvl, score); end
        n_checks++; if (spd !== 20'd30000) begin n_fail++; $display("FAIL speed_floor got %0d exp 30000", spd); end
        for (int i = 0; i < 247; i++) do_win();
        n_checks++; if (score !== 8'd255 || lvl !== 4'd15) begin n_fail++; $display("FAIL score255 got %0d/%0d exp 255/15", score, lvl); end
        do_win();
        n_checks++; if (score !== 8'd255 || lvl !== 4'd15 || spd !== 20'd30000) begin n_fail++; $display("FAIL saturate got %0d/%0d/%0d exp 255/15/30000", score, lvl, spd); end
    endtask

    task automatic test_back_to_back;
        top = 1'b1; step(1); top = 1'b0;
        tick = 1'b1; step(2); tick = 1'b0;
        n_checks++; if (resp !== 1'b1 || st !== 3'd1) begin n_fail++; $display("FAIL b2b_win_resp got %b/%0d exp 1/1", resp, st); end
        coll = 1'b1; step(1); coll = 1'b0;
        n_checks++; if (st !== 3'd2 || life !== 4'd1 || resp !== 1'b0) begin n_fail++; $display("FAIL b2b_hit got %0d/%0d/%b exp 2/1/0", st, life, resp); end
        tick = 1'b1; step(3); tick = 1'b0;
        n_checks++; if (st !== 3'd1) begin n_fail++; $display("FAIL b2b_exit got %0d exp 1", st); end
    endtask

    task automatic test_over;
        start1 = 1'b1; step(1); start1 = 1'b0;
        n_checks++; if (st1 !== 3'd1 || life1 !== 4'd1) begin n_fail++; $display("FAIL over_start got %0d/%0d exp 1/1", st1, life1); end
        coll1 = 1'b1; step(1); coll1 = 1'b0;
        n_checks++; if (st1 !== 3'd4 || life1 !== 4'd0) begin n_fail++; $display("FAIL over_entry got %0d/%0d exp 4/0", st1, life1); end
        n_checks++; if ({act1, frz1, resp1} !== 3'b000) begin n_fail++; $display("FAIL over_flags got %b exp 000", {act1, frz1, resp1}); end
        start1 = 1'b1; step(1); start1 = 1'b0;
        n_checks++; if (st1 !== 3'd4 || life1 !== 4'd0) begin n_fail++; $display("FAIL over_start_ignored got %0d/%0d exp 4/0", st1, life1); end
        tick1 = 1'b1; step(2);
        n_checks++; if (st1 !== 3'd4) begin n_fail++; $display("FAIL over_two_ticks got %0d exp 4", st1); end
        step(1); tick1 = 1'b0;
        n_checks++; if (st1 !== 3'd0 || life1 !== 4'd0) begin n_fail++; $display("FAIL over_exit got %0d/%0d exp 0/0", st1, life1); end
        start1 = 1'b1; step(1); start1 = 1'b0;
        coll1 = 1'b1; step(1); coll1 = 1'b0;
        tick1 = 1'b1; step(1); tick1 = 1'b0;
        #2 rst1_n = 1'b0; #1;
        n_checks++; if (st1 !== 3'd0 || life1 !== 4'd1 || resp1 !== 1'b0) begin n_fail++; $display("FAIL over_reset got %0d/%0d/%b exp 0/1/0", st1, life1, resp1); end
        step(1); rst1_n = 1'b1; step(1);
        n_checks++; if (st1 !== 3'd0 || resp1 !== 1'b0) begin n_fail++; $display("FAIL over_reset_release got %0d/%b exp 0/0", st1, resp1); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_hit_hold();
        test_win();
        test_levels();
        test_back_to_back();
        test_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
